// File: rtl/cpu_seq.sv
// Run/step sequencer for picoMIPS: gates PC/ACC/regfile through one clock-enable.
// Stalls on switch-input instructions until GO, single-steps, and halts on branch-to-self.
module cpu_seq #(
    parameter int p_size    = 6,
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sw_go,
    input  logic              step_mode,
    input  logic              in_en,
    input  logic [p_size-1:0] pc_out,
    output logic              cpu_en,
    output logic              in_take,
    output logic              halted,
    output logic              busy,
    output logic [CNT_W-1:0]  instr_count
);

    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_WAIT_IN,
        S_WAIT_REL,
        S_STEP,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync_q, sync_d;
    logic              go_db_q, go_db_d;
    logic              go_prev_q, go_prev_d;
    logic [DB_W-1:0]   cnt_q, cnt_d;
    logic [p_size-1:0] last_pc_q, last_pc_d;
    logic              pc_valid_q, pc_valid_d;
    logic [CNT_W-1:0]  instr_count_q, instr_count_d;
    logic              go_rise;

    assign go_rise = go_db_q & ~go_prev_q;

    always_comb begin
        sync1_d   = sw_go;
        sync_d    = sync1_q;
        go_db_d   = go_db_q;
        go_prev_d = go_db_q;
        cnt_d     = cnt_q;
        if (sync_q == go_db_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_MAX) begin
            go_db_d = sync_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cpu_en  = 1'b0;
        in_take = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go_rise) state_d = step_mode ? S_STEP : S_RUN;
            end
            S_RUN: begin
                if (step_mode)  state_d = S_STEP;
                else if (in_en) state_d = S_WAIT_IN;
                else            cpu_en  = 1'b1;
            end
            S_WAIT_IN: begin
                if (go_rise) begin
                    cpu_en  = 1'b1;
                    in_take = 1'b1;
                    state_d = S_WAIT_REL;
                end
            end
            // Wait for GO release so one press cannot feed two input instructions.
            S_WAIT_REL: begin
                if (!go_db_q) state_d = step_mode ? S_STEP : S_RUN;
            end
            S_STEP: begin
                if (go_rise) begin
                    cpu_en  = 1'b1;
                    in_take = in_en;
                end else if (!step_mode) begin
                    state_d = S_RUN;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        // An enabled cycle that re-executes the previous PC is the branch-to-self idiom.
        if (cpu_en && pc_valid_q && (pc_out == last_pc_q)) state_d = S_HALT;
    end

    always_comb begin
        last_pc_d     = cpu_en ? pc_out : last_pc_q;
        pc_valid_d    = pc_valid_q | cpu_en;
        instr_count_d = instr_count_q;
        if (cpu_en && (instr_count_q != '1)) instr_count_d = instr_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            sync1_q       <= 1'b0;
            sync_q        <= 1'b0;
            go_db_q       <= 1'b0;
            go_prev_q     <= 1'b0;
            cnt_q         <= '0;
            last_pc_q     <= '0;
            pc_valid_q    <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync_q        <= sync_d;
            go_db_q       <= go_db_d;
            go_prev_q     <= go_prev_d;
            cnt_q         <= cnt_d;
            last_pc_q     <= last_pc_d;
            pc_valid_q    <= pc_valid_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign halted      = (state_q == S_HALT);
    assign busy        = (state_q == S_RUN) || (state_q == S_STEP);
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_cpu_seq.sv
// Directed bench for cpu_seq: GO debounce latency, input stall, stepping, halt, saturation.
module tb_cpu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        sw_go;
    logic        step_mode;
    logic        in_en;
    logic [5:0]  pc_out;
    logic        cpu_en, in_take, halted, busy;
    logic [15:0] instr_count;
    logic        s_cpu_en, s_in_take, s_halted, s_busy;
    logic [3:0]  s_instr_count;
    logic        pc_hold;
    int          errors = 0;
    int          checks = 0;

    cpu_seq #(.p_size(6), .DB_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .sw_go(sw_go), .step_mode(step_mode),
        .in_en(in_en), .pc_out(pc_out), .cpu_en(cpu_en), .in_take(in_take),
        .halted(halted), .busy(busy), .instr_count(instr_count)
    );

    // Narrow counter copy fed identical stimulus to reach saturation quickly.
    cpu_seq #(.p_size(6), .DB_CYCLES(4), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .sw_go(sw_go), .step_mode(step_mode),
        .in_en(in_en), .pc_out(pc_out), .cpu_en(s_cpu_en), .in_take(s_in_take),
        .halted(s_halted), .busy(s_busy), .instr_count(s_instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; the bench plays the CPU and advances the PC after each enabled cycle.
    task automatic cpu_tick();
        logic en;
        #1;
        en = cpu_en;
        @(posedge clk);
        #1;
        if (en && !pc_hold) pc_out = pc_out + 6'd1;
        #1;
    endtask

    // Returns in the go_rise cycle.
    task automatic press();
        sw_go = 1'b1;
        repeat (6) cpu_tick();
    endtask

    task automatic release_go();
        sw_go = 1'b0;
        repeat (6) cpu_tick();
    endtask

    initial begin
        reset = 1'b1; sw_go = 1'b0; step_mode = 1'b0; in_en = 1'b0;
        pc_out = 6'd0; pc_hold = 1'b0;
        repeat (3) cpu_tick();
        reset = 1'b0;
        #1;
        chk("rst_cpu_en", cpu_en, 1'b0);
        chk("rst_in_take", in_take, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", instr_count, 16'd0);

        // GO latency: go_rise cycle after E0+5, RUN from edge E0+6
        press();
        chk("go_rise_idle_en", cpu_en, 1'b0);
        chk("go_rise_idle_busy", busy, 1'b0);
        cpu_tick();
        chk("run_first_en", cpu_en, 1'b1);
        chk("run_busy", busy, 1'b1);
        repeat (5) cpu_tick();
        chk("run_pc5", pc_out, 6'd5);
        chk("run_count5", instr_count, 16'd5);

        // Input instruction at PC=5 stalls in the same cycle
        in_en = 1'b1;
        #1;
        chk("stall_same_cycle_en", cpu_en, 1'b0);
        chk("stall_same_cycle_take", in_take, 1'b0);
        cpu_tick();
        chk("wait_in_busy", busy, 1'b0);
        chk("wait_in_en", cpu_en, 1'b0);
        release_go();
        chk("wait_in_no_press_en", cpu_en, 1'b0);
        press();
        chk("in_go_en", cpu_en, 1'b1);
        chk("in_go_take", in_take, 1'b1);
        cpu_tick();
        chk("in_go_count", instr_count, 16'd6);
        chk("wait_rel_en", cpu_en, 1'b0);
        chk("wait_rel_take", in_take, 1'b0);
        repeat (3) cpu_tick();
        chk("held_go_no_take", in_take, 1'b0);
        chk("held_go_pc", pc_out, 6'd6);
        release_go();
        cpu_tick();
        chk("rel_to_run_busy", busy, 1'b1);
        chk("rel_run_in_en_stall", cpu_en, 1'b0);
        cpu_tick();
        press();
        chk("second_in_take", in_take, 1'b1);
        cpu_tick();
        in_en = 1'b0;
        release_go();
        cpu_tick();
        chk("back_to_run_en", cpu_en, 1'b1);
        chk("count7", instr_count, 16'd7);

        // Single-step: three presses give three enabled cycles
        step_mode = 1'b1;
        #1;
        chk("run_step_en", cpu_en, 1'b0);
        cpu_tick();
        chk("step_busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) in_en = 1'b1;
            press();
            chk("step_go_en", cpu_en, 1'b1);
            chk("step_take", in_take, (i == 2));
            cpu_tick();
            in_en = 1'b0;
            release_go();
            chk("step_idle_en", cpu_en, 1'b0);
            chk("step_stay_busy", busy, 1'b1);
        end
        chk("step_count10", instr_count, 16'd10);

        // step_mode dropped in the go_rise cycle: step still taken
        press();
        step_mode = 1'b0;
        #1;
        chk("step_drop_en", cpu_en, 1'b1);
        cpu_tick();
        chk("after_drop_en", cpu_en, 1'b0);
        chk("after_drop_busy", busy, 1'b1);
        cpu_tick();
        chk("drop_to_run_en", cpu_en, 1'b1);
        chk("count11", instr_count, 16'd11);

        repeat (3) cpu_tick();
        chk("count14", instr_count, 16'd14);
        chk("narrow_count14", s_instr_count, 4'd14);
        repeat (3) cpu_tick();
        chk("count17", instr_count, 16'd17);
        chk("narrow_sat", s_instr_count, 4'hF);

        // Branch to self at PC=12
        pc_hold = 1'b1;
        pc_out = 6'd12;
        cpu_tick();
        chk("halt_first_pass_en", cpu_en, 1'b1);
        chk("halt_first_pass_halted", halted, 1'b0);
        cpu_tick();
        chk("halted", halted, 1'b1);
        chk("halt_en", cpu_en, 1'b0);
        chk("halt_busy", busy, 1'b0);
        chk("halt_count", instr_count, 16'd19);
        release_go();
        press();
        chk("halt_ignores_go", cpu_en, 1'b0);
        cpu_tick();
        chk("halt_sticky", halted, 1'b1);
        chk("halt_count_hold", instr_count, 16'd19);
        chk("narrow_halt_count", s_instr_count, 4'hF);

        sw_go = 1'b0;
        reset = 1'b1;
        cpu_tick();
        reset = 1'b0;
        #1;
        chk("unhalt_halted", halted, 1'b0);
        chk("unhalt_busy", busy, 1'b0);
        chk("unhalt_count", instr_count, 16'd0);

        // Bounce with 2-cycle pulses must not register
        sw_go = 1'b1; repeat (2) cpu_tick();
        sw_go = 1'b0; repeat (2) cpu_tick();
        sw_go = 1'b1; repeat (2) cpu_tick();
        sw_go = 1'b0; repeat (8) cpu_tick();
        chk("bounce_busy", busy, 1'b0);
        chk("bounce_en", cpu_en, 1'b0);
        chk("bounce_count", instr_count, 16'd0);

        // Reset in the middle of RUN
        pc_hold = 1'b0;
        press();
        cpu_tick();
        repeat (2) cpu_tick();
        chk("pre_reset_count", instr_count, 16'd2);
        sw_go = 1'b0;
        reset = 1'b1;
        cpu_tick();
        reset = 1'b0;
        #1;
        chk("midrun_reset_en", cpu_en, 1'b0);
        chk("midrun_reset_busy", busy, 1'b0);
        chk("midrun_reset_count", instr_count, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
